// File: rtl/mem_stage.sv
`default_nettype none

// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of the five-stage in-order pipeline.
//               Holds the instruction handed over by execute, extracts and
//               extends load data from the synchronous data SRAM, resolves
//               branches from the ALU flags and redirects fetch exactly once
//               per taken branch, taps its result to decode for forwarding
//               and passes the result on to writeback.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 121
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif
`ifndef BR_BUS_WD
`define BR_BUS_WD 33
`endif
`ifndef MS_FWD_BUS_WD
`define MS_FWD_BUS_WD 38
`endif

module mem_stage (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ws_allowin,
    output logic                          ms_allowin,
    input  logic                          es_to_ms_valid,
    input  logic [`ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
    input  logic [31:0]                   data_sram_rdata,
    output logic                          ms_to_ws_valid,
    output logic [`MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
    output logic [`BR_BUS_WD-1:0]         br_bus,
    output logic [`MS_FWD_BUS_WD-1:0]     ms_fwd_bus
);

    // ------------------------------------------------------------------
    // branch_op one-hot bit positions
    // ------------------------------------------------------------------
    localparam int unsigned c_BR_BEQ  = 0;
    localparam int unsigned c_BR_BNE  = 1;
    localparam int unsigned c_BR_BLT  = 2;
    localparam int unsigned c_BR_BGE  = 3;
    localparam int unsigned c_BR_BLTU = 4;
    localparam int unsigned c_BR_BGEU = 5;

    // load_op one-hot bit positions
    localparam int unsigned c_LD_B    = 0;
    localparam int unsigned c_LD_H    = 1;
    localparam int unsigned c_LD_W    = 2;
    localparam int unsigned c_LD_BU   = 3;
    localparam int unsigned c_LD_HU   = 4;

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic                         r_ms_valid_q;
    logic                         w_ms_valid_d;
    logic [`ES_TO_MS_BUS_WD-1:0]  r_bus_q;
    logic [`ES_TO_MS_BUS_WD-1:0]  w_bus_d;
    logic                         r_br_done_q;
    logic                         w_br_done_d;
    logic                         r_first_q;
    logic                         w_first_d;
    logic [31:0]                  r_rdata_hold_q;
    logic [31:0]                  w_rdata_hold_d;

    // Handshake
    logic                         w_ms_ready_go;
    logic                         w_load;
    logic                         w_leave;

    // Decoded bus fields
    logic [31:0]                  w_br_target;
    logic [8:0]                   w_branch_op;
    logic                         w_carry;
    logic                         w_sign;
    logic                         w_overflow;
    logic                         w_zero;
    logic [4:0]                   w_load_op;
    logic                         w_mem_to_reg;
    logic                         w_reg_we;
    logic [4:0]                   w_dest;
    logic [31:0]                  w_alu_result;
    logic [31:0]                  w_pc;

    // Branch resolution
    logic                         w_eq;
    logic                         w_slt;
    logic                         w_ult;
    logic                         w_cond;
    logic                         w_br_taken;

    // Load data path
    logic [31:0]                  w_raw_rdata;
    logic [7:0]                   w_byte;
    logic [15:0]                  w_half;
    logic [31:0]                  w_load_data;
    logic [31:0]                  w_final_result;

    // ------------------------------------------------------------------
    // Field extraction from the held execute bus
    // ------------------------------------------------------------------
    assign w_br_target  = r_bus_q[120:89];
    assign w_branch_op  = r_bus_q[88:80];
    assign w_carry      = r_bus_q[79];
    assign w_sign       = r_bus_q[78];
    assign w_overflow   = r_bus_q[77];
    assign w_zero       = r_bus_q[76];
    assign w_load_op    = r_bus_q[75:71];
    assign w_mem_to_reg = r_bus_q[70];
    assign w_reg_we     = r_bus_q[69];
    assign w_dest       = r_bus_q[68:64];
    assign w_alu_result = r_bus_q[63:32];
    assign w_pc         = r_bus_q[31:0];

    // ------------------------------------------------------------------
    // Handshake: this stage always completes in one cycle
    // ------------------------------------------------------------------
    assign w_ms_ready_go  = 1'b1;
    assign ms_allowin     = !r_ms_valid_q || (w_ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid_q && w_ms_ready_go;
    assign w_load         = es_to_ms_valid && ms_allowin;
    assign w_leave        = r_ms_valid_q && w_ms_ready_go && ws_allowin;

    // ------------------------------------------------------------------
    // Branch condition from the flags of src1 - src2 (Carry = borrow)
    // ------------------------------------------------------------------
    assign w_eq  = w_zero;
    assign w_slt = w_sign ^ w_overflow;
    assign w_ult = w_carry;

    // Combine conditional compares with the unconditional b/bl/jirl group
    always_comb begin
        w_cond = 1'b0;
        if ((w_branch_op[c_BR_BEQ]  &&  w_eq)  ||
            (w_branch_op[c_BR_BNE]  && !w_eq)  ||
            (w_branch_op[c_BR_BLT]  &&  w_slt) ||
            (w_branch_op[c_BR_BGE]  && !w_slt) ||
            (w_branch_op[c_BR_BLTU] &&  w_ult) ||
            (w_branch_op[c_BR_BGEU] && !w_ult) ||
            (|w_branch_op[8:6])) begin
            w_cond = 1'b1;
        end
    end

    // Redirect is suppressed once it has been issued for this instruction
    assign w_br_taken = r_ms_valid_q && w_cond && !r_br_done_q;
    assign br_bus     = {w_br_taken, w_br_target};

    // ------------------------------------------------------------------
    // Load data: live SRAM data in the first MS cycle, held copy after
    // ------------------------------------------------------------------
    assign w_raw_rdata = r_first_q ? data_sram_rdata : r_rdata_hold_q;

    // Byte lane by address bits [1:0], halfword lane by address bit [1]
    always_comb begin
        w_byte = w_raw_rdata[7:0];
        case (w_alu_result[1:0])
            2'd0:    w_byte = w_raw_rdata[7:0];
            2'd1:    w_byte = w_raw_rdata[15:8];
            2'd2:    w_byte = w_raw_rdata[23:16];
            default: w_byte = w_raw_rdata[31:24];
        endcase
        w_half = w_alu_result[1] ? w_raw_rdata[31:16] : w_raw_rdata[15:0];
    end

    // Sign- or zero-extend according to the one-hot load type
    always_comb begin
        w_load_data = 32'd0;
        if (w_load_op[c_LD_B]) begin
            w_load_data = {{24{w_byte[7]}}, w_byte};
        end else if (w_load_op[c_LD_H]) begin
            w_load_data = {{16{w_half[15]}}, w_half};
        end else if (w_load_op[c_LD_W]) begin
            w_load_data = w_raw_rdata;
        end else if (w_load_op[c_LD_BU]) begin
            w_load_data = {24'd0, w_byte};
        end else if (w_load_op[c_LD_HU]) begin
            w_load_data = {16'd0, w_half};
        end
    end

    assign w_final_result = w_mem_to_reg ? w_load_data : w_alu_result;

    // ------------------------------------------------------------------
    // Outputs to writeback and to decode's forwarding network
    // ------------------------------------------------------------------
    assign ms_to_ws_bus = {w_reg_we, w_dest, w_final_result, w_pc};
    assign ms_fwd_bus   = {r_ms_valid_q && w_reg_we, w_dest, w_final_result};

    // Next-state for the pipeline register, redirect-once flag and load hold
    always_comb begin
        w_ms_valid_d   = r_ms_valid_q;
        w_bus_d        = r_bus_q;
        w_br_done_d    = r_br_done_q;
        w_first_d      = w_load;
        w_rdata_hold_d = r_rdata_hold_q;

        if (ms_allowin) begin
            w_ms_valid_d = es_to_ms_valid;
        end

        if (w_load) begin
            w_bus_d     = es_to_ms_bus;
            w_br_done_d = 1'b0;
        end else if (w_br_taken && !w_leave) begin
            w_br_done_d = 1'b1;
        end

        if (r_first_q) begin
            w_rdata_hold_d = data_sram_rdata;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid_q   <= 1'b0;
            r_bus_q        <= '0;
            r_br_done_q    <= 1'b0;
            r_first_q      <= 1'b0;
            r_rdata_hold_q <= 32'd0;
        end else begin
            r_ms_valid_q   <= w_ms_valid_d;
            r_bus_q        <= w_bus_d;
            r_br_done_q    <= w_br_done_d;
            r_first_q      <= w_first_d;
            r_rdata_hold_q <= w_rdata_hold_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none

// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. Table-driven single
//               instructions plus hand-written stall/redirect/forward
//               sequences; writeback hand-offs are checked by a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_stage;

    logic          clk;
    logic          reset;
    logic          ws_allowin;
    logic          ms_allowin;
    logic          es_to_ms_valid;
    logic [120:0]  es_to_ms_bus;
    logic [31:0]   data_sram_rdata;
    logic          ms_to_ws_valid;
    logic [69:0]   ms_to_ws_bus;
    logic [32:0]   br_bus;
    logic [37:0]   ms_fwd_bus;

    int checks = 0;
    int errors = 0;

    logic [69:0] sb_q[$];

    typedef struct {
        logic [8:0]  br_op;
        logic        c, s, o, z;
        logic [4:0]  ld_op;
        logic        m2r;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic [31:0] exp_res;
        logic        exp_br;
    } vec_t;

    vec_t vecs[14];

    mem_stage u_dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .br_bus          (br_bus),
        .ms_fwd_bus      (ms_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [8:0] br_op, input logic [3:0] csoz,
                                input logic [4:0] ld_op, input logic m2r, input logic we,
                                input logic [4:0] dest, input logic [31:0] alu,
                                input logic [31:0] pc, input logic [31:0] tgt,
                                input logic [31:0] rdata, input logic [31:0] exp_res,
                                input logic exp_br);
        vec_t v;
        v.br_op = br_op; v.c = csoz[3]; v.s = csoz[2]; v.o = csoz[1]; v.z = csoz[0];
        v.ld_op = ld_op; v.m2r = m2r; v.we = we; v.dest = dest; v.alu = alu;
        v.pc = pc; v.tgt = tgt; v.rdata = rdata; v.exp_res = exp_res; v.exp_br = exp_br;
        return v;
    endfunction

    // Present one instruction from execute; optionally expect it at writeback
    task automatic drive(input vec_t v, input bit push);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {v.tgt, v.br_op, v.c, v.s, v.o, v.z, v.ld_op, v.m2r, v.we,
                          v.dest, v.alu, v.pc};
        if (push) sb_q.push_back({v.we, v.dest, v.exp_res, v.pc});
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every writeback hand-off must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected actual=%h required=none", ms_to_ws_bus);
            end else begin
                chk("wb_handoff", ms_to_ws_bus, sb_q.pop_front());
            end
        end
    end

    initial begin : main
        vec_t v;
        vec_t v2;
        int   cnt;

        //             br_op        CSOZ     ld_op    m2r we dest alu           pc            tgt           rdata         exp_res       br
        vecs[0]  = mk(9'h000, 4'b0000, 5'b00001, 1, 1, 5'd3, 32'h0000_1002, 32'h0000_0100, 32'h0, 32'h12F4_5678, 32'hFFFF_FFF4, 0);
        vecs[1]  = mk(9'h000, 4'b0000, 5'b01000, 1, 1, 5'd4, 32'h0000_1002, 32'h0000_0104, 32'h0, 32'h12F4_5678, 32'h0000_00F4, 0);
        vecs[2]  = mk(9'h000, 4'b0000, 5'b00100, 1, 1, 5'd5, 32'h0000_1000, 32'h0000_0108, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        vecs[3]  = mk(9'h000, 4'b0000, 5'b10000, 1, 1, 5'd6, 32'h0000_1000, 32'h0000_010C, 32'h0, 32'h8001_F00D, 32'h0000_F00D, 0);
        vecs[4]  = mk(9'h000, 4'b0000, 5'b00010, 1, 1, 5'd7, 32'h0000_1001, 32'h0000_0110, 32'h0, 32'h0000_8123, 32'hFFFF_8123, 0);
        vecs[5]  = mk(9'h000, 4'b0000, 5'b00001, 1, 1, 5'd8, 32'h0000_0003, 32'h0000_0114, 32'h0, 32'h7F00_0000, 32'h0000_007F, 0);
        vecs[6]  = mk(9'h004, 4'b0100, 5'b00000, 0, 0, 5'd0, 32'h0000_0011, 32'h0000_0118, 32'h8000_0040, 32'h0, 32'h0000_0011, 1);
        vecs[7]  = mk(9'h010, 4'b0000, 5'b00000, 0, 0, 5'd0, 32'h0000_0022, 32'h0000_011C, 32'h8000_0080, 32'h0, 32'h0000_0022, 0);
        vecs[8]  = mk(9'h002, 4'b0001, 5'b00000, 0, 0, 5'd0, 32'h0000_0033, 32'h0000_0120, 32'h8000_00C0, 32'h0, 32'h0000_0033, 0);
        vecs[9]  = mk(9'h008, 4'b0110, 5'b00000, 0, 0, 5'd0, 32'h0000_0044, 32'h0000_0124, 32'h8000_0100, 32'h0, 32'h0000_0044, 1);
        vecs[10] = mk(9'h020, 4'b1000, 5'b00000, 0, 0, 5'd0, 32'h0000_0055, 32'h0000_0128, 32'h8000_0140, 32'h0, 32'h0000_0055, 0);
        vecs[11] = mk(9'h100, 4'b0000, 5'b00000, 0, 1, 5'd1, 32'h0000_0130, 32'h0000_012C, 32'h8000_0180, 32'h0, 32'h0000_0130, 1);
        vecs[12] = mk(9'h001, 4'b0000, 5'b00000, 0, 0, 5'd0, 32'h0000_0066, 32'h0000_0130, 32'h8000_01C0, 32'h0, 32'h0000_0066, 0);
        vecs[13] = mk(9'h000, 4'b0000, 5'b00100, 0, 1, 5'd9, 32'h0000_1234, 32'h0000_0134, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234, 0);

        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0; data_sram_rdata = 32'd0;

        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_allowin", 70'(ms_allowin), 70'(1'b1));
        chk("rst_valid", 70'(ms_to_ws_valid), 70'(1'b0));
        chk("rst_br_bus", 70'(br_bus), 70'(33'd0));
        chk("rst_fwd_we", 70'(ms_fwd_bus[37]), 70'(1'b0));
        next_cycle();
        reset = 1'b0;

        // Table: one instruction, result checked in its first MS cycle
        for (int i = 0; i < 14; i++) begin
            ws_allowin = 1'b1;
            drive(vecs[i], 1'b1);
            next_cycle();
            es_to_ms_valid  = 1'b0;
            data_sram_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_br_taken", i), 70'(br_bus[32]), 70'(vecs[i].exp_br));
            chk($sformatf("v%0d_br_target", i), 70'(br_bus[31:0]), 70'(vecs[i].tgt));
            chk($sformatf("v%0d_fwd", i), 70'(ms_fwd_bus),
                70'({vecs[i].we, vecs[i].dest, vecs[i].exp_res}));
            next_cycle();
        end

        // ld.h held across a 3-cycle writeback stall while SRAM data changes
        v = mk(9'h000, 4'b0000, 5'b00010, 1, 1, 5'd10, 32'h0000_2002, 32'h0000_0200,
               32'h0, 32'h0, 32'hFFFF_8001, 0);
        drive(v, 1'b1);
        next_cycle();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h8001_0000;
        ws_allowin      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ldh_stall%0d_res", k), 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF_8001));
            chk($sformatf("ldh_stall%0d_allowin", k), 70'(ms_allowin), 70'(1'b0));
            next_cycle();
            data_sram_rdata = 32'd0;
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        next_cycle();

        // Taken beq stalled 4 cycles: one redirect; the next beq, accepted
        // in the release cycle, redirects again in its own first cycle
        v  = mk(9'h001, 4'b0001, 5'b00000, 0, 0, 5'd0, 32'h0000_0055, 32'h0000_0300,
                32'h0000_4000, 32'h0, 32'h0000_0055, 1);
        v2 = mk(9'h001, 4'b0001, 5'b00000, 0, 0, 5'd0, 32'h0000_0066, 32'h0000_0304,
                32'h0000_6000, 32'h0, 32'h0000_0066, 1);
        drive(v, 1'b1);
        next_cycle();
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("beq_first_cycle", 70'(br_bus), 70'({1'b1, 32'h0000_4000}));
            cnt += int'(br_bus[32]);
            next_cycle();
        end
        ws_allowin = 1'b1;
        drive(v2, 1'b1);
        @(negedge clk);
        cnt += int'(br_bus[32]);
        chk("beq_stall_pulses", 70'(cnt), 70'(1));
        next_cycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("beq2_redirect", 70'(br_bus), 70'({1'b1, 32'h0000_6000}));
        next_cycle();

        // Back-to-back ALU ops r5, r6, then a bubble, then r7
        v  = mk(9'h000, 4'b0000, 5'b00000, 0, 1, 5'd5, 32'h0000_0505, 32'h0000_0400,
                32'h0, 32'h0, 32'h0000_0505, 0);
        v2 = mk(9'h000, 4'b0000, 5'b00000, 0, 1, 5'd6, 32'h0000_0606, 32'h0000_0404,
                32'h0, 32'h0, 32'h0000_0606, 0);
        drive(v, 1'b1);
        next_cycle();
        drive(v2, 1'b1);
        @(negedge clk);
        chk("fwd_r5", 70'(ms_fwd_bus), 70'({1'b1, 5'd5, 32'h0000_0505}));
        next_cycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("fwd_r6", 70'(ms_fwd_bus), 70'({1'b1, 5'd6, 32'h0000_0606}));
        next_cycle();
        v = mk(9'h000, 4'b0000, 5'b00000, 0, 1, 5'd7, 32'h0000_0707, 32'h0000_040C,
               32'h0, 32'h0, 32'h0000_0707, 0);
        drive(v, 1'b1);
        @(negedge clk);
        chk("fwd_bubble", 70'(ms_fwd_bus[37]), 70'(1'b0));
        next_cycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("fwd_r7", 70'(ms_fwd_bus), 70'({1'b1, 5'd7, 32'h0000_0707}));
        next_cycle();

        // Reset while a taken branch is stalled drops it with no redirect
        v = mk(9'h004, 4'b0100, 5'b00000, 0, 1, 5'd2, 32'h0000_0077, 32'h0000_0500,
               32'h0000_8000, 32'h0, 32'h0000_0077, 1);
        drive(v, 1'b0);
        next_cycle();
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b0;
        @(negedge clk);
        chk("rststall_pre_taken", 70'(br_bus[32]), 70'(1'b1));
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rststall_valid", 70'(ms_to_ws_valid), 70'(1'b0));
        chk("rststall_br", 70'(br_bus[32]), 70'(1'b0));
        chk("rststall_fwd_we", 70'(ms_fwd_bus[37]), 70'(1'b0));
        next_cycle();
        reset      = 1'b0;
        ws_allowin = 1'b1;
        next_cycle();

        chk("sb_drained", 70'(sb_q.size()), 70'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline. It sits directly downstream of the execute stage and consumes its bus. It does four things:
- extracts and sign/zero-extends load data returned by the synchronous data SRAM;
- resolves branches from the ALU flags and redirects fetch;
- provides a forwarding tap to decode;
- passes results to writeback.

It uses the same valid/allowin handshake as every other stage.

## Interface
- Parameters: none. Widths come from `ES_TO_MS_BUS_WD` (121), `MS_TO_WS_BUS_WD` (70), `BR_BUS_WD` (33) and `MS_FWD_BUS_WD` (38) in the shared header.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ws_allowin`  in  1  writeback can accept this cycle.
- `ms_allowin`  out  1  this stage can accept from execute.
- `es_to_ms_valid`  in  1  execute presents a valid instruction.
- `es_to_ms_bus`  in  121  fields, MSB to LSB:
  - br_target[120:89]
  - branch_op[88:80]
  - Carry[79]
  - Sign[78]
  - Overflow[77]
  - Zero[76]
  - load_op[75:71]
  - mem_to_reg[70]
  - reg_we[69]
  - dest[68:64]
  - alu_result[63:32]
  - pc[31:0]
- `data_sram_rdata`  in  32  read data for the address execute issued in the previous cycle.
- `ms_to_ws_valid`  out  1  valid to writeback.
- `ms_to_ws_bus`  out  70  {reg_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- `br_bus`  out  33  {br_taken[32], br_target[31:0]} to fetch.
- `ms_fwd_bus`  out  38  {fwd_we[37], dest[36:32], final_result[31:0]} to decode.

## Operation
- **Pipeline register.**
  - `ms_valid` loads `es_to_ms_valid` whenever `ms_allowin`.
  - The bus register loads only when `es_to_ms_valid && ms_allowin`.
  - `ms_ready_go = 1`.
  - `ms_allowin = !ms_valid || ws_allowin`.
  - `ms_to_ws_valid = ms_valid`.
- **branch_op encoding (one-hot).** bit0 beq, bit1 bne, bit2 blt, bit3 bge, bit4 bltu, bit5 bgeu, bit6 b, bit7 bl, bit8 jirl. All-zero means not a branch.
- **Flags** come from src1 − src2.
  - eq = Zero.
  - slt = Sign ^ Overflow.
  - ult = Carry, where Carry = 1 means a borrow occurred.
- **Taken condition** is the OR of:
  - beq&eq, bne&!eq, blt&slt, bge&!slt, bltu&ult, bgeu&!ult;
  - any of bits 6–8 (unconditional).
- **Branch redirect.**
  - `br_taken = ms_valid & cond & !br_done`.
  - `br_target` is the bus field, unchanged.
  - `br_done` is a one-bit flag:
    - set when `br_taken` is asserted and the instruction does not leave MS this cycle;
    - cleared when a new instruction is loaded, or on reset.
  - Redirect therefore pulses exactly once per taken branch, even if MS stalls.
- **Load hold.**
  - `first` flag is set when the bus register loads and cleared on the following edge.
  - While `first` is set, the raw read data is the live `data_sram_rdata`; it is also captured into `rdata_hold`.
  - While `first` is clear (stalled), the raw read data comes from `rdata_hold`.
  - This makes load data stable across `ws_allowin` stalls.
- **load_op encoding (one-hot).** bit0 ld.b, bit1 ld.h, bit2 ld.w, bit3 ld.bu, bit4 ld.hu.
- **Byte/halfword selection.**
  - Byte: byte `alu_result[1:0]` of the raw read data.
  - Halfword: `alu_result[1]` selects the upper or lower half.
  - .b and .h sign-extend; .bu and .hu zero-extend; ld.w passes all 32 bits.
- **Result selection.** `final_result` = extended load data if `mem_to_reg`, else `alu_result`.
- **Forwarding.** `fwd_we = ms_valid & reg_we`; outputs `dest` and `final_result`.

## Timing
- **Reset values:** `ms_valid` = 0, `br_done` = 0, `first` = 0, `rdata_hold` = 0. Hence `ms_to_ws_valid` = 0, `br_taken` = 0 and `fwd_we` = 0; `ms_allowin` = 1.
- **Latency:** one cycle from the execute handshake to `ms_to_ws_valid`. A load's SRAM data is used in its first MS cycle, with no extra stall.
- `br_bus` and `ms_fwd_bus` are combinational from stage state. Fetch sees `br_taken` in the instruction's first MS cycle.
- **Stall** (`ms_valid && !ws_allowin`):
  - bus register, `rdata_hold` and outputs are frozen;
  - `br_taken` drops after its single cycle.
- **Same-cycle accept and release:** a new instruction enters as the old one leaves. `br_done` and `first` follow the new instruction.
- **Reset mid-stall** drops the instruction with no redirect. Flushing younger instructions on `br_taken` is done upstream, not here.
- A misaligned access (e.g. ld.h with `alu_result[0]` = 1) is not checked; it uses `alu_result[1]` only.

## Test plan
- **Reset:** hold `reset` 2 cycles → `ms_allowin` = 1, `ms_to_ws_valid` = 0, `br_bus` = 0, `fwd_we` = 0.
- **Byte loads:** ld.b at addr 0x…2 with rdata 0x12F4_5678 → `final_result` 0xFFFF_FFF4. The same access as ld.bu → 0x0000_00F4.
- **Halfword load under stall:** ld.h at addr 0x…2, rdata 0x8001_0000, `ws_allowin` = 0 for 3 cycles, and `data_sram_rdata` changed to 0 after the first cycle → result stays 0xFFFF_8001 throughout, then is handed over.
- **Conditional branches:**
  - blt with Sign = 1, Overflow = 0 → `br_taken` for 1 cycle, target passed through.
  - bltu with Carry = 0 → not taken.
  - bne with Zero = 1 → not taken.
- **Taken beq stalled:** Zero = 1, `ws_allowin` low for 4 cycles → `br_taken` high exactly 1 cycle. The next beq loaded afterwards pulses again.
- **Back-to-back ALU ops, no stall:** two ALU ops writing r5 then r6 → `ms_fwd_bus` shows r5 then r6 on consecutive cycles with `fwd_we` = 1. A bubble in between gives `fwd_we` = 0.
